// File: rtl/stream_demux4_pkg.sv
// Shared definitions for the four-way stream demultiplexer: channel
// count, select width and the per-channel slot state encoding.
package stream_demux4_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/stream_demux4_slot.sv
// demux_slot: single-entry holding slot for one output channel.
// A load writes the payload and marks the slot FULL; a drain empties it.
// Load and drain in the same cycle keep the slot FULL with the new payload,
// so a channel that is read every cycle never shows a bubble.
module demux_slot
    import stream_demux4_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [WIDTH-1:0] q,
    output slot_state_t      state
);

    slot_state_t state_nxt;

    // State register; reset empties the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a load always wins, otherwise a drain empties the slot.
    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = FULL;
        end else if (drain) begin
            state_nxt = EMPTY;
        end
    end

    // Payload register; only a load changes it, so data is stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= data;
        end
    end

    assign valid = (state == FULL);

endmodule

// File: rtl/stream_demux4.sv
// stream_demux4: routes one input stream to four output channels chosen by
// in_sel, with one single-entry slot per channel.
// Optional per-channel transfer counters (out_cnt) are built only when the
// macro STREAM_DEMUX4_CNT_EN is defined.
//
// Handshake: every interface is valid/ready. A transfer happens on a rising
// edge where valid and ready are both high; valid never depends on ready,
// and a held payload stays stable until it is taken. in_ready depends only
// on the selected slot and its out_ready, never on in_valid.
module stream_demux4
    import stream_demux4_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data
`ifdef STREAM_DEMUX4_CNT_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] out_cnt
`endif
);

    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] drain;
    logic [WIDTH-1:0]  slot_q     [NUM_CH];
    slot_state_t       slot_state [NUM_CH];

    // Input may enter when the selected slot is empty or is being emptied now.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            in_ready = (slot_state[in_sel] == EMPTY) || out_ready[in_sel];
        end
    end

    // Per-channel load and drain strobes; nothing transfers during reset.
    always_comb begin
        load  = '0;
        drain = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            load[ch]  = in_valid && in_ready && (in_sel == SEL_W'(ch));
            drain[ch] = !rst && out_valid[ch] && out_ready[ch];
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load[ch]),
            .drain (drain[ch]),
            .data  (in_data),
            .valid (out_valid[ch]),
            .q     (slot_q[ch]),
            .state (slot_state[ch])
        );

        assign out_data[ch*WIDTH +: WIDTH] = slot_q[ch];
    end

`ifdef STREAM_DEMUX4_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];

    // Count completed output transfers per channel, wrapping at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (drain[ch]) begin
                    cnt_q[ch] <= cnt_q[ch] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_cnt
        assign out_cnt[ch*CNT_W +: CNT_W] = cnt_q[ch];
    end
`endif

endmodule

// File: doc/stream_demux4.md
STREAM_DEMUX4 -- requirements
Module: stream_demux4

Interface
REQ-001 SHALL have parameter WIDTH, default 2, payload width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, per-channel transfer counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  input payload valid.
REQ-006 SHALL have port in_ready  output  1  input accepted this cycle when high with in_valid.
REQ-007 SHALL have port in_data  input  WIDTH  input payload.
REQ-008 SHALL have port in_sel  input  2  destination channel 0..3; sampled only when in_valid=1.
REQ-009 SHALL have port out_valid  output  4  per-channel valid, bit ch = channel ch.
REQ-010 SHALL have port out_ready  input  4  per-channel ready.
REQ-011 SHALL have port out_data  output  4*WIDTH  per-channel payload, channel ch at bits [ch*WIDTH +: WIDTH].
REQ-012 SHALL have port out_cnt  output  4*CNT_W  per-channel output transfer count, channel ch at [ch*CNT_W +: CNT_W]; present only per REQ-027.

Function
REQ-013 SHALL hold one single-entry slot per channel, each with states EMPTY and FULL.
REQ-014 SHALL drive in_ready = (slot[in_sel] EMPTY) or out_ready[in_sel]; combinational, no dependency on in_valid.
REQ-015 SHALL accept on in_valid && in_ready: slot[in_sel] loads in_data, becomes FULL next cycle; latency from acceptance to out_valid is exactly 1 cycle.
REQ-016 SHALL drive out_valid[ch]=1 iff slot ch FULL; out_data for ch equals slot contents.
REQ-017 SHALL complete an output transfer on out_valid[ch] && out_ready[ch]; slot goes EMPTY next cycle unless loaded the same cycle.
REQ-018 SHALL, on simultaneous drain and load of one slot, stay FULL holding the new payload; no bubble, no loss.
REQ-019 SHALL keep out_data[ch] stable while out_valid[ch]=1 and out_ready[ch]=0.
REQ-020 SHALL leave non-selected slots unchanged; a stalled channel blocks input only while in_sel points to it.
REQ-021 SHALL keep EMPTY slots' out_data at last value (0 after reset); value is don't-care for checking.
REQ-022 SHALL never duplicate, drop or reorder payloads within one channel.

Reset
REQ-023 SHALL on rst=1 at a clock edge set all slots EMPTY, out_valid=4'b0000, out_data=0, out_cnt=0.
REQ-024 SHALL discard buffered payloads when reset asserts mid-operation; no transfer completes in a reset cycle.
REQ-025 SHALL force in_ready=0 while rst=1.

Configuration
REQ-026 SHALL compile counters only when macro STREAM_DEMUX4_CNT_EN is defined.
REQ-027 SHALL with STREAM_DEMUX4_CNT_EN: expose out_cnt; channel count increments by 1 per REQ-017 transfer, wraps 2^CNT_W-1 to 0; without it: out_cnt port and counter logic absent, all other behaviour identical.

Structure
REQ-028 SHALL place NUM_CH=4, SEL_W=2 and the slot state enum (EMPTY, FULL) in shared package stream_demux4_pkg.
REQ-029 SHALL implement each slot as sub-module demux_slot (load, drain, data, valid), instantiated 4 times.

Verification
REQ-030 SHALL cover: reset, then in_data=2'b10, in_sel=2, in_valid=1, out_ready=4'b1111 -> next cycle out_valid=4'b0100, channel 2 data 2'b10.
REQ-031 SHALL cover: out_ready[1]=0, two sends to channel 1 (2'b01 then 2'b11) -> first held stable, in_ready=0 for second until out_ready[1]=1, then 2'b11 follows with no loss.
REQ-032 SHALL cover: channel 0 stalled FULL, send 2'b11 to channel 3 -> in_ready=1, channel 3 valid next cycle, channel 0 unchanged.
REQ-033 SHALL cover: channel 2 FULL, out_ready[2]=1 with new load to channel 2 same cycle -> out_valid[2] stays 1, data becomes new payload.
REQ-034 SHALL cover: rst asserted with slots 0 and 3 FULL -> next cycle out_valid=4'b0000, out_cnt=0, no further transfers.
REQ-035 SHALL cover (STREAM_DEMUX4_CNT_EN, CNT_W=8): 257 transfers on channel 1 -> channel 1 count reads 1, other counts 0.
